// File: rtl/pixel_writer.sv
// Region write-back engine: buffers filtered pixels in a small FIFO and writes them
// to image memory in raster order using the address/enable/DRDY handshake.
//
// state  | meaning
// S_IDLE | waiting for Wrt_Start; FIFO still accepts pixels
// S_WAIT | region active, waiting for a pixel in the FIFO
// S_REQ  | write request held on the bus until Wrt_DRDY
// S_DONE | one-cycle Wrt_Done pulse, then back to idle
module pixel_writer #(
  parameter int DATA_WIDTH = 24,
  parameter int BUS_WIDTH  = 32,
  parameter int IMG_WIDTH  = 512,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  Wrt_Clk,
  input  logic                  Wrt_Rset,
  input  logic                  Wrt_Start,
  input  logic [BUS_WIDTH-1:0]  Wrt_Rstrt,
  input  logic [BUS_WIDTH-1:0]  Wrt_Cstrt,
  input  logic [BUS_WIDTH-1:0]  Wrt_Rcnt,
  input  logic [BUS_WIDTH-1:0]  Wrt_Ccnt,
  input  logic [DATA_WIDTH-1:0] Wrt_PixData,
  input  logic                  Wrt_PixValid,
  output logic                  Wrt_PixReady,
  output logic [BUS_WIDTH-1:0]  Wrt_MemAddr,
  output logic [DATA_WIDTH-1:0] Wrt_MemData,
  output logic [1:0]            Wrt_Wen,
  input  logic                  Wrt_DRDY,
  output logic                  Wrt_Busy,
  output logic                  Wrt_Done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [BUS_WIDTH-1:0] IMG_W = BUS_WIDTH'(IMG_WIDTH);
  localparam logic [BUS_WIDTH-1:0] ONE   = BUS_WIDTH'(1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_REQ, S_DONE} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  push, pop;

  logic [BUS_WIDTH-1:0]  row, col, cstrt, col_last, rows_left;
  logic [BUS_WIDTH-1:0]  addr_next;

  assign Wrt_PixReady = (count != CNT_W'(FIFO_DEPTH));
  assign push         = Wrt_PixValid && Wrt_PixReady;
  assign pop          = (state == S_WAIT) && (count != '0);
  assign addr_next    = row * IMG_W + col;

  always_ff @(posedge Wrt_Clk) begin
    if (push) fifo_mem[wr_ptr] <= Wrt_PixData;
  end

  always_ff @(posedge Wrt_Clk or negedge Wrt_Rset) begin
    if (!Wrt_Rset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // rows_left counts down whole rows; the last write is the end column of the final row
  always_ff @(posedge Wrt_Clk or negedge Wrt_Rset) begin
    if (!Wrt_Rset) begin
      state       <= S_IDLE;
      row         <= '0;
      col         <= '0;
      cstrt       <= '0;
      col_last    <= '0;
      rows_left   <= '0;
      Wrt_MemAddr <= '0;
      Wrt_MemData <= '0;
      Wrt_Wen     <= 2'b00;
      Wrt_Busy    <= 1'b0;
      Wrt_Done    <= 1'b0;
    end else begin
      Wrt_Done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Wrt_Start) begin
            row       <= Wrt_Rstrt;
            col       <= Wrt_Cstrt;
            cstrt     <= Wrt_Cstrt;
            col_last  <= Wrt_Cstrt + Wrt_Ccnt - ONE;
            rows_left <= Wrt_Rcnt;
            if (Wrt_Rcnt == '0 || Wrt_Ccnt == '0) begin
              state    <= S_DONE;
              Wrt_Done <= 1'b1;
            end else begin
              state    <= S_WAIT;
              Wrt_Busy <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (pop) begin
            Wrt_MemData <= fifo_mem[rd_ptr];
            Wrt_MemAddr <= addr_next;
            Wrt_Wen     <= 2'b01;
            state       <= S_REQ;
          end
        end
        S_REQ: begin
          if (Wrt_DRDY) begin
            Wrt_Wen <= 2'b00;
            if (col == col_last) begin
              col       <= cstrt;
              row       <= row + ONE;
              rows_left <= rows_left - ONE;
              if (rows_left == ONE) begin
                state    <= S_DONE;
                Wrt_Busy <= 1'b0;
                Wrt_Done <= 1'b1;
              end else begin
                state <= S_WAIT;
              end
            end else begin
              col   <= col + ONE;
              state <= S_WAIT;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/pixel_writer.md
# pixel_writer

Write-back engine for the median filter: accepts filtered pixels over a valid/ready stream, buffers them in a small FIFO, and writes them to image memory in raster order over a rectangular output region. It drives the memory write side of the same address/enable/DRDY protocol that the window reader uses for reads, and it sits between the filter core and Memory.

## Interface
- DATA_WIDTH, 24, pixel width (RGB)
- BUS_WIDTH, 32, address and region-coordinate width
- IMG_WIDTH, 512, image row pitch in pixels
- FIFO_DEPTH, 4, input FIFO entries (power of two, ≥2)

Ports:
- Wrt_Clk  in  1  the block's single clock; rising edge
- Wrt_Rset  in  1  reset; asynchronous, active-low
- Wrt_Start  in  1  one-cycle pulse; starts a region write
- Wrt_Rstrt  in  BUS_WIDTH  first row of region; sampled on Start
- Wrt_Cstrt  in  BUS_WIDTH  first column of region; sampled on Start
- Wrt_Rcnt  in  BUS_WIDTH  region height in rows; sampled on Start
- Wrt_Ccnt  in  BUS_WIDTH  region width in columns; sampled on Start
- Wrt_PixData  in  DATA_WIDTH  filtered pixel
- Wrt_PixValid  in  1  PixData valid
- Wrt_PixReady  out  1  FIFO can accept; equals not-full
- Wrt_MemAddr  out  BUS_WIDTH  write address
- Wrt_MemData  out  DATA_WIDTH  write data
- Wrt_Wen  out  2  memory command: 2'b01 write request, 2'b00 idle
- Wrt_DRDY  in  1  memory write acknowledge, sampled on clock
- Wrt_Busy  out  1  region write in progress
- Wrt_Done  out  1  one-cycle pulse; region complete

## Operation
- FIFO push: on each edge where PixValid && PixReady. Pushes are accepted in every state, including IDLE, so the FIFO can be prefilled. Data is stored in order.
- PixReady = (count != FIFO_DEPTH). It is combinational from the registered count.
- Simultaneous push and pop: the count is unchanged and both take effect.
- FSM states: IDLE, WAIT, REQ, DONE.
  - IDLE: on Start, latch Rstrt/Cstrt/Rcnt/Ccnt and set row=Rstrt, col=Cstrt. If Rcnt==0 or Ccnt==0, go to DONE; otherwise go to WAIT. Start is ignored in all other states.
  - WAIT: if the FIFO is non-empty, pop the head and register MemData=head, MemAddr=row*IMG_WIDTH+col (truncated to BUS_WIDTH), and Wen=2'b01, then go to REQ. Otherwise stay in WAIT.
  - REQ: hold MemAddr, MemData and Wen. On an edge with DRDY=1, set Wen=2'b00 and advance the position.
    - If col == Cstrt+Ccnt-1, set col=Cstrt and row=row+1; otherwise set col=col+1.
    - If the pixel just written was the last one (Rcnt*Ccnt writes done), go to DONE; otherwise go to WAIT.
  - DONE: Done=1 for this one cycle, then go to IDLE.
- Busy = 1 in WAIT and REQ, 0 in IDLE and DONE.
- Coordinates are not clamped to the image. Columns past IMG_WIDTH produce linear addresses as computed.
- Pixels left in the FIFO after DONE remain queued for the next region.

## Timing
- Reset values: MemAddr=0, MemData=0, Wen=2'b00, Busy=0, Done=0, FIFO empty (PixReady=1), FSM in IDLE, row=col=0.
- Reset assertion takes effect immediately, even mid-write. Wen drops to 2'b00 asynchronously and any in-flight write is abandoned with no Done. The first Start is honoured on the first edge after reset release.
- Start at edge N puts Busy high after edge N.
- Fastest write cycle: pixel present in FIFO → Wen high one edge after entering WAIT.
- DRDY sampled at edge M → Wen low after M. The next Wen is no earlier than after edge M+1, so Wen is low for at least one full cycle between writes.
- Per-pixel cost: memory acknowledge latency + 2 cycles.
- DRDY while not in REQ: ignored.
- Done rises after the edge that enters DONE and falls one cycle later. Busy falls on the same edge that Done rises.
- Zero-size region: Done pulses in the cycle after the Start edge, with no Wen activity.

## Test plan
- Basic write: Rstrt=1, Cstrt=1, Rcnt=2, Ccnt=2, IMG_WIDTH=512, pixels A,B,C,D pushed, memory ACK 2 cycles after Wen. Expect:
  - Writes in order (513,A), (514,B), (1025,C), (1026,D).
  - Wen low ≥1 cycle between writes.
  - Exactly one Done pulse; Busy low afterwards.
- Row wrap with no clamping: Rstrt=10, Cstrt=510, Rcnt=2, Ccnt=3 → addresses 5630, 5631, 5632, 6142, 6143, 6144.
- Backpressure: FIFO_DEPTH=4, DRDY held 0, PixValid held 1 from Start. Expect:
  - 5 pixels accepted (1 in REQ, 4 buffered), then PixReady=0.
  - After one DRDY pulse, PixReady=1 for exactly one accept.
- Zero-size region: Rcnt=0, Ccnt=5, Start → Done one cycle later; Wen stays 2'b00 and the FIFO is untouched.
- Start while Busy: a second Start with different coordinates during REQ is ignored; the address sequence of the first region is unchanged.
- Reset mid-write: assert Wrt_Rset=0 while Wen=2'b01. Expect:
  - Wen=0, MemAddr=0, PixReady=1, Busy=0 with no clock edge.
  - After release, a fresh 1×1 region at (0,0) writes address 0 and pulses Done.
